// File: rtl/control_secuencia.sv
// -----------------------------------------------------------------------------
// control_secuencia
//
// Purpose:
//   Sequencer that drives a small datapath (two operand muxes, an ALU and a
//   register bank).  On a start request it latches one instruction and repeats
//   an ASSIGN/SAVE pair op_cnt times (0 counts as 1).  ASSIGN presents the
//   control codes.  SAVE keeps the codes and pulses the write enable of the
//   destination register.  A single DONE cycle then reports completion.
//   Every output comes straight from a register (Moore style).
//
// Optional feature (macro CTRL_OVF_ABORT_EN):
//   When the macro is defined, fov=1 seen during an ASSIGN cycle suppresses
//   that iteration's write pulse and ends the operation with err=1.
//   When it is undefined, fov only goes into the flags and err is always 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   new-operation request, honoured only in IDLE
//   op_a/op_b  in   operand-A / operand-B mux codes           [SELW]
//   op_alu     in   ALU function code                         [SELW]
//   op_reg     in   register-bank instruction code            [SELW]
//   op_dst     in   destination register index                [4]
//   op_cnt     in   iteration count, 0 treated as 1           [CNTW]
//   fov, fcarry, fneg, fzero  in  ALU flags
//   instmulta/instmultb/instalu/instreg  out  registered control codes [SELW]
//   escr       out  one-hot register write enables            [NREG]
//   busy       out  high in ASSIGN and SAVE
//   done       out  one-cycle completion pulse
//   err        out  abort indication, valid together with done
//   flags      out  {fov,fcarry,fneg,fzero} captured for the last SAVE
// -----------------------------------------------------------------------------
module control_secuencia #(
  parameter int NREG = 4,
  parameter int SELW = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [SELW-1:0] op_a,
  input  logic [SELW-1:0] op_b,
  input  logic [SELW-1:0] op_alu,
  input  logic [SELW-1:0] op_reg,
  input  logic [3:0]      op_dst,
  input  logic [CNTW-1:0] op_cnt,
  input  logic            fov,
  input  logic            fcarry,
  input  logic            fneg,
  input  logic            fzero,
  output logic [SELW-1:0] instmulta,
  output logic [SELW-1:0] instmultb,
  output logic [SELW-1:0] instalu,
  output logic [SELW-1:0] instreg,
  output logic [NREG-1:0] escr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [3:0]      flags
);

`ifdef CTRL_OVF_ABORT_EN
  localparam bit OvfAbortEn = 1'b1;
`else
  localparam bit OvfAbortEn = 1'b0;
`endif

  localparam logic [CNTW-1:0] OneCount = CNTW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ASSIGN,
    SAVE,
    DONE
  } state_t;

  state_t          state_q;
  logic [SELW-1:0] instA_q;
  logic [SELW-1:0] instB_q;
  logic [SELW-1:0] instAlu_q;
  logic [SELW-1:0] instReg_q;
  logic [NREG-1:0] escr_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [3:0]      flags_q;
  logic [3:0]      dst_q;
  logic [CNTW-1:0] remCount_q;
  logic            abort_q;

  logic [NREG-1:0] escrHot_d;
  logic [CNTW-1:0] startCount_d;
  logic            ovfAbort_d;

  // Decode the latched destination into a one-hot write enable.  An index
  // of NREG or above matches no lane, so such an operation never writes.
  // A zero count is promoted to one.  An overflow abort only exists when
  // the optional feature is built in.
  always_comb begin
    escrHot_d = '0;
    for (int i = 0; i < NREG; i++) begin
      escrHot_d[i] = (dst_q == 4'(i));
    end
    startCount_d = (op_cnt == '0) ? OneCount : op_cnt;
    ovfAbort_d   = OvfAbortEn && fov;
  end

  // The whole sequencer is one registered process.  Each transition loads
  // the output registers with the values the destination state presents.
  // The control-code registers double as the instruction latch, so they
  // keep their value across iterations and clear only on the way into DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instA_q    <= '0;
      instB_q    <= '0;
      instAlu_q  <= '0;
      instReg_q  <= '0;
      escr_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      flags_q    <= '0;
      dst_q      <= '0;
      remCount_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          escr_q <= '0;
          if (start) begin
            instA_q    <= op_a;
            instB_q    <= op_b;
            instAlu_q  <= op_alu;
            instReg_q  <= op_reg;
            dst_q      <= op_dst;
            remCount_q <= startCount_d;
            abort_q    <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ASSIGN;
          end
        end
        // Flags are sampled while the ALU result for this iteration is
        // settled, so the SAVE cycle shows what is being written.
        ASSIGN: begin
          flags_q <= {fov, fcarry, fneg, fzero};
          if (ovfAbort_d) begin
            abort_q <= 1'b1;
            escr_q  <= '0;
          end else begin
            escr_q  <= escrHot_d;
          end
          state_q <= SAVE;
        end
        SAVE: begin
          escr_q     <= '0;
          remCount_q <= remCount_q - OneCount;
          if (abort_q || remCount_q == OneCount) begin
            instA_q   <= '0;
            instB_q   <= '0;
            instAlu_q <= '0;
            instReg_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            err_q     <= abort_q;
            state_q   <= DONE;
          end else begin
            state_q   <= ASSIGN;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          abort_q    <= 1'b0;
          remCount_q <= '0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign instmulta = instA_q;
  assign instmultb = instB_q;
  assign instalu   = instAlu_q;
  assign instreg   = instReg_q;
  assign escr      = escr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign flags     = flags_q;

endmodule
